// File: rtl/attack_hit_detect.sv
// Per-player attack phase FSM with hitbox/hurtbox overlap and one-hit-per-swing pulse generation.
// Optional one-deep request buffer during recovery: define ATTACK_BUFFER_EN.
module attack_hit_detect #(
  parameter int unsigned BODY_W          = 32,
  parameter int unsigned BODY_H          = 48,
  parameter int unsigned HITBOX_W        = 24,
  parameter int unsigned HITBOX_H        = 16,
  parameter int unsigned HITBOX_Y_OFF    = 12,
  parameter int unsigned LIGHT_STARTUP   = 3,
  parameter int unsigned HEAVY_STARTUP   = 8,
  parameter int unsigned ACTIVE_FRAMES   = 3,
  parameter int unsigned RECOVERY_FRAMES = 6,
  parameter int unsigned LIGHT_DAMAGE    = 6,
  parameter int unsigned HEAVY_DAMAGE    = 14
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_frame_tick,
  input  logic       i_attack_req,
  input  logic       i_attack_heavy,
  input  logic       i_facing_left,
  input  logic [9:0] i_attacker_x,
  input  logic [9:0] i_attacker_y,
  input  logic [9:0] i_defender_x,
  input  logic [9:0] i_defender_y,
  input  logic       i_attacker_stunned,
  input  logic       i_defender_hitstun,
  output logic       o_got_hit,
  output logic [5:0] o_hit_damage,
  output logic [1:0] o_attack_state,
  output logic       o_attack_active
);

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StStartup  = 2'd1,
    StActive   = 2'd2,
    StRecovery = 2'd3
  } state_e;

  localparam logic [10:0] BodyW   = 11'(BODY_W);
  localparam logic [10:0] BodyH   = 11'(BODY_H);
  localparam logic [10:0] HitW    = 11'(HITBOX_W);
  localparam logic [10:0] HitH    = 11'(HITBOX_H);
  localparam logic [10:0] HitYOff = 11'(HITBOX_Y_OFF);

  localparam logic [7:0] LightStartup   = 8'(LIGHT_STARTUP);
  localparam logic [7:0] HeavyStartup   = 8'(HEAVY_STARTUP);
  localparam logic [7:0] ActiveFrames   = 8'(ACTIVE_FRAMES);
  localparam logic [7:0] RecoveryFrames = 8'(RECOVERY_FRAMES);
  localparam logic [5:0] LightDamage    = 6'(LIGHT_DAMAGE);
  localparam logic [5:0] HeavyDamage    = 6'(HEAVY_DAMAGE);

  state_e     r_state, w_state_d;
  logic [7:0] r_cnt, w_cnt_d;
  logic       r_heavy, w_heavy_d;
  logic       r_hit_landed, w_hit_landed_d;
  logic       r_got_hit, w_got_hit_d;
  logic [5:0] r_damage, w_damage_d;
`ifdef ATTACK_BUFFER_EN
  logic       r_buf_req, w_buf_req_d;
  logic       r_buf_heavy, w_buf_heavy_d;
`endif

  // Geometry in 11 bits so right-side sums never wrap.
  logic [10:0] w_ax, w_ay, w_dx, w_dy;
  logic [10:0] w_hx_lo, w_hx_hi, w_hy_lo, w_hy_hi, w_dx_hi, w_dy_hi;
  logic        w_overlap;

  assign w_ax    = {1'b0, i_attacker_x};
  assign w_ay    = {1'b0, i_attacker_y};
  assign w_dx    = {1'b0, i_defender_x};
  assign w_dy    = {1'b0, i_defender_y};
  assign w_hy_lo = w_ay + HitYOff;
  assign w_hy_hi = w_ay + HitYOff + HitH;
  assign w_dx_hi = w_dx + BodyW;
  assign w_dy_hi = w_dy + BodyH;

  always_comb begin
    if (i_facing_left) begin
      w_hx_lo = (w_ax >= HitW) ? (w_ax - HitW) : 11'd0;
      w_hx_hi = w_ax;
    end else begin
      w_hx_lo = w_ax + BodyW;
      w_hx_hi = w_ax + BodyW + HitW;
    end
  end

  assign w_overlap = (w_hx_lo < w_dx_hi) && (w_dx < w_hx_hi) &&
                     (w_hy_lo < w_dy_hi) && (w_dy < w_hy_hi);

  always_comb begin
    w_state_d      = r_state;
    w_cnt_d        = r_cnt;
    w_heavy_d      = r_heavy;
    w_hit_landed_d = r_hit_landed;
    w_got_hit_d    = 1'b0;
    w_damage_d     = r_damage;
`ifdef ATTACK_BUFFER_EN
    w_buf_req_d    = i_attacker_stunned ? 1'b0 : r_buf_req;
    w_buf_heavy_d  = r_buf_heavy;
`endif
    // Stun cancels any swing outright and outranks the frame tick.
    if (r_state != StIdle && i_attacker_stunned) begin
      w_state_d = StIdle;
    end else begin
      case (r_state)
        StIdle: begin
          if (i_attack_req && !i_attacker_stunned) begin
            w_state_d      = StStartup;
            w_heavy_d      = i_attack_heavy;
            w_cnt_d        = i_attack_heavy ? HeavyStartup : LightStartup;
            w_hit_landed_d = 1'b0;
          end
        end
        StStartup: begin
          if (i_frame_tick) begin
            if (r_cnt == 8'd1) begin
              w_state_d = StActive;
              w_cnt_d   = ActiveFrames;
            end else begin
              w_cnt_d = r_cnt - 8'd1;
            end
          end
        end
        StActive: begin
          if (i_frame_tick) begin
            if (w_overlap && !r_hit_landed && !i_defender_hitstun) begin
              w_got_hit_d    = 1'b1;
              w_hit_landed_d = 1'b1;
              w_damage_d     = r_heavy ? HeavyDamage : LightDamage;
            end
            if (r_cnt == 8'd1) begin
              w_state_d = StRecovery;
              w_cnt_d   = RecoveryFrames;
            end else begin
              w_cnt_d = r_cnt - 8'd1;
            end
          end
        end
        StRecovery: begin
`ifdef ATTACK_BUFFER_EN
          if (i_attack_req) begin
            w_buf_req_d   = 1'b1;
            w_buf_heavy_d = i_attack_heavy;
          end
`endif
          if (i_frame_tick) begin
            if (r_cnt == 8'd1) begin
              w_state_d = StIdle;
`ifdef ATTACK_BUFFER_EN
              if (w_buf_req_d) begin
                w_state_d      = StStartup;
                w_heavy_d      = w_buf_heavy_d;
                w_cnt_d        = w_buf_heavy_d ? HeavyStartup : LightStartup;
                w_hit_landed_d = 1'b0;
                w_buf_req_d    = 1'b0;
              end
`endif
            end else begin
              w_cnt_d = r_cnt - 8'd1;
            end
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= StIdle;
      r_cnt        <= 8'd0;
      r_heavy      <= 1'b0;
      r_hit_landed <= 1'b0;
      r_got_hit    <= 1'b0;
      r_damage     <= 6'd0;
`ifdef ATTACK_BUFFER_EN
      r_buf_req    <= 1'b0;
      r_buf_heavy  <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_d;
      r_cnt        <= w_cnt_d;
      r_heavy      <= w_heavy_d;
      r_hit_landed <= w_hit_landed_d;
      r_got_hit    <= w_got_hit_d;
      r_damage     <= w_damage_d;
`ifdef ATTACK_BUFFER_EN
      r_buf_req    <= w_buf_req_d;
      r_buf_heavy  <= w_buf_heavy_d;
`endif
    end
  end

  assign o_got_hit       = r_got_hit;
  assign o_hit_damage    = r_damage;
  assign o_attack_state  = r_state;
  assign o_attack_active = (r_state == StActive);

endmodule

// File: doc/attack_hit_detect.md
Name: attack_hit_detect

Overview:
- Per-player attack state machine plus hitbox/hurtbox overlap check; sits directly upstream of the defender's hit/damage FSM.
- Produces the defender's got_hit pulse and hit damage amount.
- Registers at most one hit per attack swing.
- Exposes attack phase for sprite/animation logic.

Parameters:
- BODY_W, 32, hurtbox width in pixels (both players).
- BODY_H, 48, hurtbox height in pixels.
- HITBOX_W, 24, attack hitbox width.
- HITBOX_H, 16, attack hitbox height.
- HITBOX_Y_OFF, 12, hitbox top offset below attacker_y.
- LIGHT_STARTUP, 3, startup frames for a light attack (≥1).
- HEAVY_STARTUP, 8, startup frames for a heavy attack (≥1).
- ACTIVE_FRAMES, 3, active frames (≥1).
- RECOVERY_FRAMES, 6, recovery frames (≥1).
- LIGHT_DAMAGE, 6, damage for a light hit (fits 6 bits).
- HEAVY_DAMAGE, 14, damage for a heavy hit (fits 6 bits).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- frame_tick  in  1  one-cycle pulse per video frame.
- attack_req  in  1  one-cycle attack request.
- attack_heavy  in  1  qualifies attack_req: 1 = heavy, 0 = light.
- facing_left  in  1  attacker facing; 0 = right.
- attacker_x  in  10  attacker top-left x.
- attacker_y  in  10  attacker top-left y.
- defender_x  in  10  defender top-left x.
- defender_y  in  10  defender top-left y.
- attacker_stunned  in  1  attacker in hitstun; cancels the attack.
- defender_hitstun  in  1  defender in hitstun; hits are suppressed.
- got_hit  out  1  one-cycle hit pulse to the defender's damage FSM.
- hit_damage  out  6  damage value, valid with got_hit.
- attack_state  out  2  IDLE=0, STARTUP=1, ACTIVE=2, RECOVERY=3.
- attack_active  out  1  attack_state==ACTIVE.

Behaviour:
- Reset: state IDLE, frame counter 0, hit_landed 0, heavy latch 0, got_hit 0, hit_damage 0. Reset mid-attack aborts to IDLE with no pulse.
- IDLE:
  - attack_req while !attacker_stunned → STARTUP on the next clock.
  - Latch attack_heavy on that clock; load counter with LIGHT_STARTUP or HEAVY_STARTUP; clear hit_landed.
  - attack_req is not frame-gated.
- Phase timing:
  - Counter changes only on frame_tick.
  - On frame_tick with counter==1, advance to the next phase and load its length. Otherwise decrement.
  - Each phase therefore lasts exactly N frame_ticks.
  - Order: STARTUP → ACTIVE(ACTIVE_FRAMES) → RECOVERY(RECOVERY_FRAMES) → IDLE.
- attack_req outside IDLE is ignored (see Optional Feature).
- attacker_stunned high in any non-IDLE state → IDLE on the next clock. No hit, no recovery. Takes priority over frame_tick.
- Hitbox geometry, all math in 11-bit unsigned, no wrap:
  - Right-facing: x in [ax+BODY_W, ax+BODY_W+HITBOX_W).
  - Left-facing: x in [max(ax−HITBOX_W, 0), ax). Negative edge clamps to 0.
  - y in [ay+HITBOX_Y_OFF, ay+HITBOX_Y_OFF+HITBOX_H).
- Defender hurtbox: [dx, dx+BODY_W) × [dy, dy+BODY_H).
- Overlap requires strict interval intersection on both axes. Touching edges do not overlap.
- Hit rule: frame_tick while ACTIVE, overlap true, !hit_landed and !defender_hitstun → got_hit=1 on the next clock only.
  - In the same clock, hit_damage is set to LIGHT_DAMAGE or HEAVY_DAMAGE per the latched weight, and hit_landed is set.
  - hit_damage holds its value until the next hit.
- A hit on the last ACTIVE frame_tick registers while the phase also moves to RECOVERY.
- Positions are sampled on the frame_tick cycle only.
- attack_state and attack_active are registered; they change on the clock after the deciding event.

Optional Feature:
- Macro ATTACK_BUFFER_EN.
- When defined:
  - One-deep request buffer.
  - attack_req during RECOVERY latches buffered_req and its weight. A later request overwrites it.
  - When RECOVERY expires with buffered_req set, go directly to STARTUP instead of IDLE, load the buffered weight, clear hit_landed and the buffer.
  - attacker_stunned or reset clears the buffer.
- When undefined: no buffer; a request during RECOVERY is dropped and RECOVERY→IDLE always.

Test Plan:
- Light hit: attacker (100,200) facing right, defender (140,200); attack_req light, then 12 frame_ticks.
  - One got_hit, one clock after tick 4, hit_damage=6.
  - States: STARTUP ticks 1-3, ACTIVE 4-6, RECOVERY 7-12, IDLE after tick 12.
- Edges: defender_x=156 → no got_hit. defender_x=155 → got_hit.
  - Heavy at dx=155: got_hit after tick 9, damage=14.
- Left clamp: attacker_x=10 facing left, defender (0,200) → hit.
  - Attacker_x=10 facing left, defender (1000,200) → no hit (no wraparound).
- Abort: overlap setup, attacker_stunned pulses during STARTUP tick 2 → IDLE next clock; no got_hit across 12 ticks.
- Defender hitstun: defender_hitstun high on ACTIVE tick 1, low from tick 2 → single got_hit after tick 2, none after tick 3.
- ATTACK_BUFFER_EN: attack_req heavy during RECOVERY → RECOVERY goes straight to STARTUP, lasting 8 ticks.
  - Without the macro, the same stimulus → IDLE.
